mem_ctrl: RTL and testbench

Word-addressed data memory plus access controller. It sits directly upstream of the MDR and supplies the MDR's memory-data input. It takes its address from the MAR and its write data from the MDR output. The control unit drives Read/Write as 4-phase requests and waits for MemDone, so the datapath tolerates configurable memory latency.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_ctrl_ram_array.sv | 21 ++
 rtl/mem_ctrl.sv | 106 ++++++++++
 tb/tb_mem_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: FSM encoding and the
// default address/data widths that the MAR and MDR also use.
package mem_pkg;

   localparam int MEM_ADDR_W = 9;
   localparam int MEM_DATA_W = 32;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_ctrl_ram_array.sv
// Single-port synchronous RAM: write on we, rdata registered every cycle from addr.
// Storage has no reset; contents survive a controller reset.
module ram_array #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_ctrl.sv
// Data memory access controller: 4-phase Read/Write requests, configurable
// wait states, single-cycle array access and a registered Mdatain for the MDR.
import mem_pkg::*;

module mem_ctrl #(
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DATA_W      = MEM_DATA_W,
   parameter int WAIT_STATES = 2
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [ADDR_W-1:0] MAR_addr,
   input  logic [DATA_W-1:0] MDR_data,
   input  logic              Read,
   input  logic              Write,
   output logic [DATA_W-1:0] Mdatain,
   output logic              MemDone,
   output logic              MemBusy,
   output logic              MemErr,
   output logic [1:0]        state_dbg
);

   // Handshake: Read/Write act as request levels sampled only in IDLE; MemDone
   // is the acknowledge, held until both requests drop, then the FSM returns to IDLE.
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;
   localparam mem_state_t FIRST_BUSY = (WAIT_STATES > 0) ? WAIT : ACCESS;

   mem_state_t              state_q, state_d;
   logic [WAIT_CNT_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [DATA_W-1:0]       data_q;
   logic                    op_write_q;
   logic                    err_q;
   logic [DATA_W-1:0]       mdatain_q;
   logic [DATA_W-1:0]       ram_rdata;
   logic [ADDR_W-1:0]       ram_addr;
   logic                    ram_we;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (Read && Write)      state_d = DONE;
            else if (Read || Write) state_d = FIRST_BUSY;
         end
         WAIT:    if (cnt_q == '0) state_d = ACCESS;
         ACCESS:  state_d = DONE;
         DONE:    if (!Read && !Write) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         op_write_q <= 1'b0;
         err_q      <= 1'b0;
         mdatain_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (Read && Write) begin
                  err_q <= 1'b1;
               end else if (Read || Write) begin
                  addr_q     <= MAR_addr;
                  data_q     <= MDR_data;
                  op_write_q <= Write;
                  cnt_q      <= WAIT_LOAD;
               end
            end
            WAIT:    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            ACCESS:  if (!op_write_q) mdatain_q <= ram_rdata;
            DONE:    if (state_d == IDLE) err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   // In IDLE the RAM is addressed straight from MAR so rdata is already
   // valid by the ACCESS cycle even with zero wait states.
   assign ram_addr = (state_q == IDLE) ? MAR_addr : addr_q;
   assign ram_we   = (state_q == ACCESS) && op_write_q;

   ram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (data_q),
      .rdata (ram_rdata)
   );

   assign Mdatain   = mdatain_q;
   assign MemDone   = (state_q == DONE);
   assign MemBusy   = (state_q == WAIT) || (state_q == ACCESS);
   assign MemErr    = (state_q == DONE) && err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: one instance with 2 wait states, one with none.
module tb_mem_ctrl;
   import mem_pkg::*;

   logic        clock;
   logic        clear;
   logic [8:0]  mar [2];
   logic [31:0] mdr [2];
   logic        rd  [2];
   logic        wr  [2];
   logic [31:0] mdo [2];
   logic        done[2];
   logic        busy[2];
   logic        err [2];
   logic [1:0]  st  [2];

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        r;
      logic        w;
      logic [8:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_mdo;
      logic        exp_err;
   } vec_t;

   vec_t vecs[12];

   mem_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) dut0 (
      .clock(clock), .clear(clear), .MAR_addr(mar[0]), .MDR_data(mdr[0]),
      .Read(rd[0]), .Write(wr[0]), .Mdatain(mdo[0]), .MemDone(done[0]),
      .MemBusy(busy[0]), .MemErr(err[0]), .state_dbg(st[0])
   );

   mem_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(2)) dut (
      .clock(clock), .clear(clear), .MAR_addr(mar[1]), .MDR_data(mdr[1]),
      .Read(rd[1]), .Write(wr[1]), .Mdatain(mdo[1]), .MemDone(done[1]),
      .MemBusy(busy[1]), .MemErr(err[1]), .state_dbg(st[1])
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // drivers
   task automatic wait_done(input int d, inout int lat, inout int busy_n);
      do begin
         @(posedge clock); #1;
         lat++;
         if (busy[d]) busy_n++;
      end while (!done[d] && lat < 40);
      if (!done[d]) begin
         checks++;
         failures++;
         $display("FAIL txn_timeout dut=%0d actual=no_MemDone expected=MemDone", d);
      end
   endtask

   task automatic txn(input int d, input logic r, input logic w, input logic [8:0] a,
                      input logic [31:0] v, output int lat, output int busy_n);
      @(negedge clock);
      mar[d] = a; mdr[d] = v; rd[d] = r; wr[d] = w;
      lat = 0; busy_n = 0;
      wait_done(d, lat, busy_n);
   endtask

   task automatic drop(input int d, input string tag);
      @(negedge clock);
      rd[d] = 1'b0; wr[d] = 1'b0;
      @(posedge clock); #1;
      chk({tag, "_exit_state"}, 32'(st[d]), 32'(IDLE));
      chk({tag, "_exit_done"}, 32'(done[d]), 32'd0);
      chk({tag, "_exit_err"}, 32'(err[d]), 32'd0);
   endtask

   task automatic read_expect(input int d, input logic [8:0] a, input logic [31:0] v,
                              input int exp_lat, input string tag);
      int lat, bn;
      exp_q.push_back(v);
      txn(d, 1'b1, 1'b0, a, 32'h0, lat, bn);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_mdo"}, mdo[d], exp_q.pop_front());
      drop(d, tag);
   endtask

   initial begin
      int lat, bn, ok;
      for (int d = 0; d < 2; d++) begin
         mar[d] = '0; mdr[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
      end
      clear = 1'b1;

      vecs[0]  = '{1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 9'h005, 32'h00000000, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 9'h010, 32'h12345678, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 9'h1FF, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 9'h006, 32'h66666666, 32'hDEADBEEF, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 9'h020, 32'h00000001, 32'hDEADBEEF, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 9'h010, 32'h00000000, 32'h12345678, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 9'h1FF, 32'h00000000, 32'hCAFEF00D, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 9'h000, 32'h0BADF00D, 32'hCAFEF00D, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 9'h000, 32'h00000000, 32'h0BADF00D, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 9'h010, 32'hFFFFFFFF, 32'h0BADF00D, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 9'h010, 32'h00000000, 32'h12345678, 1'b0};

      // reset asserted mid-clock: outputs clear without waiting for an edge
      @(posedge clock);
      @(negedge clock);
      clear = 1'b0;
      #1;
      chk("rst_mdo", mdo[1], 32'h0);
      chk("rst_done", 32'(done[1]), 32'd0);
      chk("rst_busy", 32'(busy[1]), 32'd0);
      chk("rst_err", 32'(err[1]), 32'd0);
      chk("rst_state", 32'(st[1]), 32'(IDLE));
      chk("rst_mdo0", mdo[0], 32'h0);
      repeat (2) @(negedge clock);
      clear = 1'b1;
      @(posedge clock); #1;
      chk("rel_state", 32'(st[1]), 32'(IDLE));
      chk("rel_busy", 32'(busy[1]), 32'd0);

      // table-driven transactions, 2 wait states
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(vecs[i].exp_mdo);
         txn(1, vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].data, lat, bn);
         chk($sformatf("v%0d_lat", i), 32'(lat), vecs[i].exp_err ? 32'd1 : 32'd4);
         chk($sformatf("v%0d_busy", i), 32'(bn), vecs[i].exp_err ? 32'd0 : 32'd3);
         chk($sformatf("v%0d_err", i), 32'(err[1]), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_mdo", i), mdo[1], exp_q.pop_front());
         drop(1, $sformatf("v%0d", i));
      end

      // held read: MemDone stays, no second access
      txn(1, 1'b1, 1'b0, 9'h005, 32'h0, lat, bn);
      chk("held_lat", 32'(lat), 32'd4);
      ok = 0;
      repeat (10) begin
         @(posedge clock); #1;
         if (done[1] && !busy[1] && st[1] == DONE && mdo[1] == 32'hDEADBEEF) ok++;
      end
      chk("held_cycles", 32'(ok), 32'd10);
      drop(1, "held");

      // address/data churn during WAIT of a write
      @(negedge clock);
      mar[1] = 9'h005; mdr[1] = 32'hA5A5A5A5; wr[1] = 1'b1;
      @(posedge clock); #1;
      chk("churn_in_wait", 32'(st[1]), 32'(WAIT));
      @(negedge clock);
      mar[1] = 9'h006; mdr[1] = 32'h11111111;
      lat = 1; bn = 1;
      wait_done(1, lat, bn);
      chk("churn_lat", 32'(lat), 32'd4);
      chk("churn_mdo", mdo[1], 32'hDEADBEEF);
      drop(1, "churn");
      read_expect(1, 9'h005, 32'hA5A5A5A5, 4, "churn_rd5");
      read_expect(1, 9'h006, 32'h66666666, 4, "churn_rd6");

      // abort a write in ACCESS, 2 wait states
      @(negedge clock);
      mar[1] = 9'h020; mdr[1] = 32'hFFFFFFFF; wr[1] = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("abort_in_access", 32'(st[1]), 32'(ACCESS));
      @(negedge clock);
      clear = 1'b0;
      #1;
      chk("abort_mdo", mdo[1], 32'h0);
      chk("abort_state", 32'(st[1]), 32'(IDLE));
      wr[1] = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      read_expect(1, 9'h020, 32'h00000001, 4, "abort_rd");

      // zero wait states: latency 2, then abort in ACCESS
      txn(0, 1'b0, 1'b1, 9'h020, 32'h00000001, lat, bn);
      chk("ws0_wr_lat", 32'(lat), 32'd2);
      chk("ws0_wr_busy", 32'(bn), 32'd1);
      chk("ws0_wr_mdo", mdo[0], 32'h0);
      drop(0, "ws0_wr");
      read_expect(0, 9'h020, 32'h00000001, 2, "ws0_rd");
      @(negedge clock);
      mar[0] = 9'h020; mdr[0] = 32'hFFFFFFFF; wr[0] = 1'b1;
      @(posedge clock); #1;
      chk("ws0_abort_in_access", 32'(st[0]), 32'(ACCESS));
      @(negedge clock);
      clear = 1'b0;
      #1;
      chk("ws0_abort_mdo", mdo[0], 32'h0);
      wr[0] = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      read_expect(0, 9'h020, 32'h00000001, 2, "ws0_abort_rd");

      // report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
